// File: rtl/count_seq_checker_if.sv
`default_nettype none
// ==========================================================================
// count_seq_checker_if : sample stream and verdict bundle of the checker
// Rev 1.0
// ==========================================================================
interface count_seq_checker_if #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
);
  logic [2:0]       cnt_in;
  logic             valid_in;
  logic [2:0]       expect_out;
  logic             locked;
  logic             dir;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;
  logic [LAP_W-1:0] lap_cnt;

  modport master (
    output cnt_in, valid_in,
    input  expect_out, locked, dir, err_pulse, err_sticky, err_cnt, lap_cnt
  );

  modport slave (
    input  cnt_in, valid_in,
    output expect_out, locked, dir, err_pulse, err_sticky, err_cnt, lap_cnt
  );
endinterface
`default_nettype wire

// File: rtl/count_seq_checker.sv
`default_nettype none
// ==========================================================================
// count_seq_checker : tracks the double-4 up/down count and flags deviations
// Rev 1.0
// ==========================================================================
module count_seq_checker #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  wire                 clk,
  input  wire                 rst_n,
  count_seq_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    UP   = 2'd1,
    DBL4 = 2'd2,
    DOWN = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       expect_q, expect_nx;
  logic             err_nx;
  logic             lap_inc;
  logic             err_pulse_q;
  logic             err_sticky_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [LAP_W-1:0] lap_cnt_q;

  always_comb begin
    state_nx  = state;
    expect_nx = expect_q;
    err_nx    = 1'b0;
    lap_inc   = 1'b0;
    if (bus.valid_in) begin
      if (state == SEEK) begin
        if (bus.cnt_in == 3'd0) begin
          state_nx  = UP;
          expect_nx = 3'd1;
        end
      end else if (bus.cnt_in != expect_q) begin
        // A stray 0 is itself a valid sequence start, so relock on it at once
        err_nx = 1'b1;
        if (bus.cnt_in == 3'd0) begin
          state_nx  = UP;
          expect_nx = 3'd1;
        end else begin
          state_nx  = SEEK;
          expect_nx = 3'd0;
        end
      end else begin
        case (state)
          UP: begin
            if (bus.cnt_in == 3'd4) begin
              state_nx  = DBL4;
              expect_nx = 3'd4;
            end else if (bus.cnt_in == 3'd7) begin
              state_nx  = DOWN;
              expect_nx = 3'd6;
            end else begin
              expect_nx = bus.cnt_in + 3'd1;
            end
          end
          DBL4: begin
            state_nx  = UP;
            expect_nx = 3'd5;
          end
          DOWN: begin
            if (bus.cnt_in == 3'd0) begin
              state_nx  = UP;
              expect_nx = 3'd1;
              lap_inc   = 1'b1;
            end else begin
              expect_nx = bus.cnt_in - 3'd1;
            end
          end
          default: begin
            state_nx  = SEEK;
            expect_nx = 3'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEEK;
      expect_q     <= 3'd0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      lap_cnt_q    <= '0;
    end else begin
      state       <= state_nx;
      expect_q    <= expect_nx;
      err_pulse_q <= err_nx;
      if (err_nx) begin
        err_sticky_q <= 1'b1;
      end
      if (err_nx && (err_cnt_q != {ERR_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
      if (lap_inc && (lap_cnt_q != {LAP_W{1'b1}})) begin
        lap_cnt_q <= lap_cnt_q + 1'b1;
      end
    end
  end

  // locked/dir decode straight from the state register, never from inputs
  assign bus.expect_out = expect_q;
  assign bus.locked     = (state != SEEK);
  assign bus.dir        = (state == DOWN);
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.lap_cnt    = lap_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// ==========================================================================
// tb_count_seq_checker : scoreboard bench driving samples against a position model
// Rev 1.0
// ==========================================================================
module tb_count_seq_checker;

  localparam int LAP_W   = 8;
  localparam int ERR_W   = 4;
  localparam int LAP_MAX = (1 << LAP_W) - 1;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  typedef struct {
    int expect_out;
    int locked;
    int dir;
    int err_pulse;
    int err_sticky;
    int err_cnt;
    int lap_cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  count_seq_checker_if #(.LAP_W(LAP_W), .ERR_W(ERR_W)) bus ();

  count_seq_checker #(.LAP_W(LAP_W), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk;
  int   n_fail;
  exp_t sb_q[$];
  int   golden[16] = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

  // Model: position of the next expected element in the golden cycle
  bit m_locked;
  int m_pos;
  bit m_sticky;
  int m_errc;
  int m_lap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    m_sticky = 1'b0;
    m_errc   = 0;
    m_lap    = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input bit v, input int s);
    exp_t e;
    e.err_pulse = 0;
    if (v) begin
      if (!m_locked) begin
        if (s == 0) begin
          m_locked = 1'b1;
          m_pos    = 1;
        end
      end else if (s == golden[m_pos]) begin
        if (m_pos == 15) begin
          m_pos = 1;
          if (m_lap < LAP_MAX) m_lap++;
        end else begin
          m_pos++;
        end
      end else begin
        e.err_pulse = 1;
        m_sticky    = 1'b1;
        if (m_errc < ERR_MAX) m_errc++;
        if (s == 0) begin
          m_locked = 1'b1;
          m_pos    = 1;
        end else begin
          m_locked = 1'b0;
        end
      end
    end
    e.expect_out = m_locked ? golden[m_pos] : 0;
    e.locked     = m_locked;
    e.dir        = (m_locked && m_pos >= 9) ? 1 : 0;
    e.err_sticky = m_sticky;
    e.err_cnt    = m_errc;
    e.lap_cnt    = m_lap;
    sb_q.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("expect_out", 32'(bus.expect_out), e.expect_out);
      chk("locked",     32'(bus.locked),     e.locked);
      chk("dir",        32'(bus.dir),        e.dir);
      chk("err_pulse",  32'(bus.err_pulse),  e.err_pulse);
      chk("err_sticky", 32'(bus.err_sticky), e.err_sticky);
      chk("err_cnt",    32'(bus.err_cnt),    e.err_cnt);
      chk("lap_cnt",    32'(bus.lap_cnt),    e.lap_cnt);
    end
  endtask

  task automatic step(input bit v, input int s);
    @(negedge clk);
    bus.valid_in = v;
    bus.cnt_in   = 3'(s);
    model_step(v, s);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_expect"}, 32'(bus.expect_out), 32'd0);
    chk({tag, "_locked"}, 32'(bus.locked),     32'd0);
    chk({tag, "_dir"},    32'(bus.dir),        32'd0);
    chk({tag, "_pulse"},  32'(bus.err_pulse),  32'd0);
    chk({tag, "_sticky"}, 32'(bus.err_sticky), 32'd0);
    chk({tag, "_errcnt"}, 32'(bus.err_cnt),    32'd0);
    chk({tag, "_lapcnt"}, 32'(bus.lap_cnt),    32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.cnt_in   = 3'd0;
    model_reset();
    @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic golden_lap(input bit toggle);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, golden[i]);
      if (toggle) step(1'b0, int'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.cnt_in   = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);

    // Clean golden lap
    do_reset();
    golden_lap(1'b0);
    chk("golden_lap1", 32'(bus.lap_cnt), 32'd1);
    chk("golden_noerr", 32'(bus.err_sticky), 32'd0);

    // Noise before the first 0 is ignored
    do_reset();
    step(1'b1, 3); step(1'b1, 5); step(1'b1, 0); step(1'b1, 1);
    chk("seek_expect2", 32'(bus.expect_out), 32'd2);
    chk("seek_noerr", 32'(bus.err_cnt), 32'd0);

    // Missing second 4
    do_reset();
    step(1'b1, 0); step(1'b1, 1); step(1'b1, 2); step(1'b1, 3); step(1'b1, 4); step(1'b1, 5);
    chk("dbl4_miss_locked", 32'(bus.locked), 32'd0);
    chk("dbl4_miss_errcnt", 32'(bus.err_cnt), 32'd1);

    // Stray 0 while ascending: relock without a lap
    do_reset();
    step(1'b1, 0); step(1'b1, 1); step(1'b1, 2); step(1'b1, 0);
    chk("relock_expect", 32'(bus.expect_out), 32'd1);
    chk("relock_lap", 32'(bus.lap_cnt), 32'd0);

    // Golden lap with valid gaps
    do_reset();
    golden_lap(1'b1);
    chk("toggle_lap1", 32'(bus.lap_cnt), 32'd1);

    // Lap counter saturation
    do_reset();
    for (int l = 0; l < 300; l++) golden_lap(1'b0);
    chk("lap_sat", 32'(bus.lap_cnt), 32'(LAP_MAX));

    // Back-to-back mismatching zeros saturate the error count
    for (int k = 0; k < 20; k++) step(1'b1, 0);
    chk("err_sat", 32'(bus.err_cnt), 32'(ERR_MAX));
    step(1'b0, 0);

    // Asynchronous reset while descending
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, golden[i]);
    chk("pre_areset_dir", 32'(bus.dir), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("areset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 5); step(1'b1, 4);
    chk("areset_nolock", 32'(bus.locked), 32'd0);
    step(1'b1, 0);
    chk("areset_lock", 32'(bus.locked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter LAP_W, default 8, width of the lap counter.
REQ-002 Parameter ERR_W, default 4, width of the mismatch counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cnt_in  input  3  sample from the upstream double-4 up/down counter.
REQ-006 valid_in  input  1  cnt_in is sampled only on edges where valid_in=1.
REQ-007 expect_out  output  3  value predicted for the next valid sample.
REQ-008 locked  output  1  1 while tracking the sequence (state != SEEK).
REQ-009 dir  output  1  0 = ascending phase, 1 = descending phase (1 only in DOWN).
REQ-010 err_pulse  output  1  one-cycle strobe: the last valid sample mismatched expect_out.
REQ-011 err_sticky  output  1  set on any mismatch; cleared only by reset.
REQ-012 err_cnt  output  ERR_W  saturating mismatch count.
REQ-013 lap_cnt  output  LAP_W  saturating count of completed 16-sample cycles.

Function
REQ-014 Golden sequence, repeating: 0,1,2,3,4,4,5,6,7,6,5,4,3,2,1,0 (period 16).
REQ-015 FSM states: SEEK, UP, DBL4, DOWN. All outputs are registered, with no combinational path from input to output.
REQ-016 With valid_in=0, all state, expect_out and counters hold, and err_pulse=0.
REQ-017 SEEK, valid sample 0 -> UP, expect_out=1. Any other value -> stay in SEEK with no error.
REQ-018 UP, match s: s=4 -> DBL4, expect 4; s=7 -> DOWN, expect 6; otherwise stay in UP, expect s+1.
REQ-019 DBL4, match (4) -> UP, expect 5.
REQ-020 DOWN, match s: s=0 -> UP, expect 1, lap_cnt increments; otherwise stay in DOWN, expect s-1.
REQ-021 Mismatch in UP, DBL4 or DOWN: on the same edge, err_pulse=1 (for one cycle), err_sticky=1 and err_cnt increments.
REQ-022 Mismatch next state: if the mismatching sample is 0 -> UP with expect 1 (immediate relock); otherwise -> SEEK with expect_out=0.
REQ-023 A mismatch never increments lap_cnt, including a 0 arriving in UP or DBL4.
REQ-024 err_cnt and lap_cnt saturate at all-ones, with no wrap.
REQ-025 The second 4 is expected only in DBL4. A 4 seen in DOWN is a normal decrement step.
REQ-026 Back-to-back mismatches each produce their own err_pulse cycle.
REQ-027 Latency: the verdict for a sample appears on err_pulse/expect_out in the cycle after the edge that captured it.

Reset
REQ-028 rst_n=0 forces, asynchronously and regardless of clk: state=SEEK, expect_out=0, locked=0, dir=0, err_pulse=0, err_sticky=0, err_cnt=0, lap_cnt=0.
REQ-029 Reset mid-sequence discards tracking. After release, the block waits in SEEK for the next valid 0.
REQ-030 Release of rst_n is synchronous to clk; the first active edge after release evaluates normally.

Verification
REQ-031 Reset, then feed 0,1,2,3,4,4,5,6,7,6,5,4,3,2,1,0 with valid_in=1 -> locked=1 after the first sample, no err_pulse, lap_cnt=1, dir=1 from sample 7 through sample 1.
REQ-032 Feed 3,5,0,1 from reset -> no error while in SEEK; lock occurs on the 0; expect_out=2 after the 1.
REQ-033 Locked, feed 0,1,2,3,4,5 (second 4 omitted) -> err_pulse on the 5, err_cnt=1, state SEEK, err_sticky=1.
REQ-034 Locked after 0,1,2, inject 0 -> err_pulse, immediate relock, expect_out=1, lap_cnt unchanged.
REQ-035 Run the golden sequence with valid_in toggling 1/0 every cycle -> results identical to REQ-031. lap_cnt held at 255 after 300 laps (LAP_W=8). err_cnt held at 15 after 20 forced mismatches.
REQ-036 Assert rst_n=0 between clock edges in DOWN -> outputs clear immediately. After release, feeding 5,4,0 -> locks only on the 0.
